// File: rtl/icache_assoc.sv
// Set-associative instruction cache: zero-latency hits, one outstanding line refill,
// round-robin replacement once a set is full, and hit/miss performance counters.
//   state | meaning
//   IDLE  | accept fetches; hits are answered combinationally in the same cycle
//   MISS  | line refill requested from memory, waiting for mem_read_valid_i
module icache_assoc #(
  parameter int unsigned NrSets         = 32,
  parameter int unsigned NrWays         = 2,
  parameter int unsigned NrWordsPerLine = 4
) (
  input  logic                           clk_i,
  input  logic                           rstn_i,
  input  logic [31:0]                    addr_i,
  input  logic                           read_en_i,
  input  logic                           flush_i,
  output logic                           read_valid_o,
  output logic [31:0]                    read_word_o,
  output logic [31:0]                    mem_addr_o,
  output logic                           mem_read_en_o,
  input  logic                           mem_read_valid_i,
  input  logic [32*NrWordsPerLine-1:0]   mem_read_data_i,
  output logic [31:0]                    hit_count_o,
  output logic [31:0]                    miss_count_o
);

  localparam int unsigned LineSize = 32 * NrWordsPerLine;
  localparam int unsigned WselBits = $clog2(NrWordsPerLine);
  localparam int unsigned OffBits  = WselBits + 2;
  localparam int unsigned IdxBits  = $clog2(NrSets);
  localparam int unsigned TagBits  = 32 - IdxBits - OffBits;
  localparam int unsigned WayBits  = $clog2(NrWays);

  typedef enum logic {IDLE, MISS} state_t;

  state_t state_q, state_d;

  logic [NrWays-1:0]   valid_q [NrSets];
  logic [WayBits-1:0]  vptr_q  [NrSets];
  logic [TagBits-1:0]  tag_q   [NrSets][NrWays];
  logic [LineSize-1:0] data_q  [NrSets][NrWays];

  logic [31-OffBits:0] miss_line_q;
  logic                flush_pend_q;
  logic [31:0]         hit_cnt_q;
  logic [31:0]         miss_cnt_q;

  logic [TagBits-1:0]  req_tag;
  logic [IdxBits-1:0]  req_idx;
  logic [WselBits-1:0] req_wsel;
  logic [IdxBits-1:0]  miss_idx;
  logic [TagBits-1:0]  miss_tag;
  logic                unused_addr_bits;

  assign req_tag          = addr_i[31:32-TagBits];
  assign req_idx          = addr_i[OffBits+IdxBits-1:OffBits];
  assign req_wsel         = addr_i[OffBits-1:2];
  assign miss_idx         = miss_line_q[IdxBits-1:0];
  assign miss_tag         = miss_line_q[31-OffBits:IdxBits];
  assign unused_addr_bits = ^addr_i[1:0];

  logic                hit;
  logic [WayBits-1:0]  hit_way;
  logic [LineSize-1:0] hit_line;
  logic [31:0]         hit_word;

  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = NrWays - 1; w >= 0; w--) begin
      if (valid_q[req_idx][w] && (tag_q[req_idx][w] == req_tag)) begin
        hit     = 1'b1;
        hit_way = WayBits'(w);
      end
    end
  end

  assign hit_line = data_q[req_idx][hit_way];

  always_comb begin
    hit_word = '0;
    for (int k = 0; k < NrWordsPerLine; k++) begin
      if (req_wsel == WselBits'(k)) hit_word = hit_line[k*32 +: 32];
    end
  end

  // Lowest invalid way wins; the round-robin pointer only matters for a full set.
  logic [WayBits-1:0] victim;
  logic               set_full;

  always_comb begin
    victim   = vptr_q[miss_idx];
    set_full = &valid_q[miss_idx];
    for (int w = NrWays - 1; w >= 0; w--) begin
      if (!valid_q[miss_idx][w]) victim = WayBits'(w);
    end
  end

  logic lookup, do_hit, do_miss, refill, refill_flush, install, flush_all;

  assign lookup       = (state_q == IDLE) && read_en_i && !flush_i;
  assign do_hit       = lookup && hit;
  assign do_miss      = lookup && !hit;
  assign refill       = (state_q == MISS) && mem_read_valid_i;
  assign refill_flush = flush_pend_q || flush_i;
  assign install      = refill && !refill_flush;
  assign flush_all    = ((state_q == IDLE) && flush_i) || (refill && refill_flush);

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (do_miss) state_d = MISS;
      MISS:    if (mem_read_valid_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    read_valid_o  = do_hit;
    read_word_o   = do_hit ? hit_word : 32'd0;
    mem_read_en_o = (state_q == MISS);
    mem_addr_o    = (state_q == MISS) ? {miss_line_q, {OffBits{1'b0}}} : 32'd0;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      valid_q      <= '{default: '0};
      vptr_q       <= '{default: '0};
      miss_line_q  <= '0;
      flush_pend_q <= 1'b0;
      hit_cnt_q    <= '0;
      miss_cnt_q   <= '0;
    end else begin
      if (flush_all) begin
        valid_q <= '{default: '0};
        vptr_q  <= '{default: '0};
      end else if (install) begin
        valid_q[miss_idx][victim] <= 1'b1;
        if (set_full) vptr_q[miss_idx] <= vptr_q[miss_idx] + WayBits'(1);
      end

      if (refill) begin
        flush_pend_q <= 1'b0;
      end else if ((state_q == MISS) && flush_i) begin
        flush_pend_q <= 1'b1;
      end

      if (do_miss) miss_line_q <= addr_i[31:OffBits];
      if (do_hit)  hit_cnt_q   <= hit_cnt_q + 32'd1;
      if (do_miss) miss_cnt_q  <= miss_cnt_q + 32'd1;
    end
  end

  // Tag and data storage carry no reset; the valid bits qualify them.
  always_ff @(posedge clk_i) begin
    if (install) begin
      tag_q[miss_idx][victim]  <= miss_tag;
      data_q[miss_idx][victim] <= mem_read_data_i;
    end
  end

  assign hit_count_o  = hit_cnt_q;
  assign miss_count_o = miss_cnt_q;

endmodule
